mem_a_data_reader: RTL and testbench

MEM_A_DATA_READER -- requirements
Module: mem_a_data_reader

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mem_a_tile_buffer.sv | 42 ++++
 rtl/mem_a_data_reader.sv | 173 +++++++++++++++++
 tb/tb_mem_a_data_reader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and derived geometry for the matrix-multiply datapath.
// Holds the A-reader FSM state type and the line/tile width helpers.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        REQ       = 3'd2,
        WAIT_RESP = 3'd3,
        PRESENT   = 3'd4
    } rd_state_e;

    localparam int BUS_WIDTH_BYTES_DEF = 32;
    localparam int ARRAY_HEIGHT_DEF    = 4;
    localparam int LINE_BITS           = BUS_WIDTH_BYTES_DEF * 8;
    localparam int TILE_BITS           = ARRAY_HEIGHT_DEF * LINE_BITS;

    function automatic int line_bits_f(input int bus_bytes);
        return bus_bytes * 8;
    endfunction

    function automatic int tile_bits_f(input int height, input int bus_bytes);
        return height * bus_bytes * 8;
    endfunction

endpackage

// File: rtl/mem_a_tile_buffer.sv
// Line storage for one A tile: DEPTH registers of LINE_W bits, written one
// line at a time and exposed as a single flattened tile word.
module mem_a_tile_buffer #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [LINE_W-1:0]         wr_data,
    output logic [DEPTH*LINE_W-1:0]   tile_data
);

    logic [LINE_W-1:0] line_r [DEPTH];

    // Line registers: cleared on reset or restart, otherwise written by index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                line_r[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                line_r[k] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < DEPTH)) begin
            line_r[wr_idx] <= wr_data;
        end
    end

    // Flatten: line k occupies bits [(k+1)*LINE_W-1 : k*LINE_W]
    always_comb begin
        tile_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            tile_data[k*LINE_W +: LINE_W] = line_r[k];
        end
    end

endmodule

// File: rtl/mem_a_data_reader.sv
// Fetches ARRAY_HEIGHT A lines (one memory beat per FIFO address) into a tile
// and hands the tile to the systolic array with a valid/ready handshake.
module mem_a_data_reader
    import mm_pkg::*;
#(
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ARRAY_HEIGHT     = 4
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start_i,
    input  logic [15:0]                             a_fifo_addr,
    input  logic                                    a_fifo_empty,
    output logic                                    a_fifo_pop,
    output logic                                    mem_req,
    output logic [15:0]                             mem_addr,
    input  logic                                    mem_gnt,
    input  logic                                    mem_rvalid,
    input  logic [BUS_WIDTH_BYTES*8-1:0]            mem_rdata,
    output logic [ARRAY_HEIGHT*BUS_WIDTH_BYTES*8-1:0] tile_data,
    output logic                                    tile_valid,
    input  logic                                    tile_ready,
    output logic [15:0]                             tile_count,
    output logic                                    err_o
);

    localparam int LINE_W = line_bits_f(BUS_WIDTH_BYTES);
    localparam int CNT_W  = $clog2(ARRAY_HEIGHT) + 1;
    localparam int IDX_W  = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(ARRAY_HEIGHT - 1);

    if ((BUS_WIDTH_BYTES % DATA_WIDTH_BYTES) != 0) begin : g_bad_elem_width
        $error("BUS_WIDTH_BYTES must hold a whole number of elements");
    end

    rd_state_e         state_r;
    logic [CNT_W-1:0]  line_cnt_r;
    logic              drop_r;
    logic              mem_req_r;
    logic [15:0]       mem_addr_r;
    logic              tile_valid_r;
    logic [15:0]       tile_count_r;
    logic              err_r;

    logic              pop_s;
    logic              resp_expected_s;
    logic              wr_en_s;
    logic              spurious_s;
    logic              last_s;
    logic              restart_drop_s;

    // Response qualification; a beat in the grant cycle belongs to that request
    always_comb begin
        pop_s           = 1'b0;
        resp_expected_s = 1'b0;
        wr_en_s         = 1'b0;
        spurious_s      = 1'b0;
        last_s          = 1'b0;
        restart_drop_s  = 1'b0;
        if ((state_r == FETCH) && !a_fifo_empty && !start_i) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        resp_expected_s = (state_r == WAIT_RESP) || ((state_r == REQ) && mem_gnt);
        wr_en_s         = mem_rvalid && !drop_r && resp_expected_s && !start_i;
        spurious_s      = mem_rvalid && !drop_r && !resp_expected_s;
        last_s          = (line_cnt_r == LAST_LINE);
        // A restart leaves a beat in flight unless it lands in this very cycle
        restart_drop_s  = (resp_expected_s && !(mem_rvalid && !drop_r)) ||
                          (drop_r && !mem_rvalid);
    end

    // Control FSM, counters and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            line_cnt_r   <= '0;
            drop_r       <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 16'h0000;
            tile_valid_r <= 1'b0;
            tile_count_r <= 16'h0000;
            err_r        <= 1'b0;
        end else if (start_i) begin
            state_r      <= FETCH;
            line_cnt_r   <= '0;
            drop_r       <= restart_drop_s;
            mem_req_r    <= 1'b0;
            tile_valid_r <= 1'b0;
            tile_count_r <= 16'h0000;
            err_r        <= 1'b0;
        end else begin
            if (spurious_s) begin
                err_r <= 1'b1;
            end
            if (drop_r && mem_rvalid) begin
                drop_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                FETCH: begin
                    if (pop_s) begin
                        mem_addr_r <= a_fifo_addr;
                        mem_req_r  <= 1'b1;
                        state_r    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        if (wr_en_s && last_s) begin
                            tile_valid_r <= 1'b1;
                            state_r      <= PRESENT;
                        end else if (wr_en_s) begin
                            line_cnt_r <= line_cnt_r + CNT_W'(1);
                            state_r    <= FETCH;
                        end else begin
                            state_r <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (wr_en_s && last_s) begin
                        tile_valid_r <= 1'b1;
                        state_r      <= PRESENT;
                    end else if (wr_en_s) begin
                        line_cnt_r <= line_cnt_r + CNT_W'(1);
                        state_r    <= FETCH;
                    end
                end
                PRESENT: begin
                    if (tile_ready) begin
                        tile_count_r <= tile_count_r + 16'd1;
                        line_cnt_r   <= '0;
                        tile_valid_r <= 1'b0;
                        state_r      <= FETCH;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    mem_req_r    <= 1'b0;
                    tile_valid_r <= 1'b0;
                end
            endcase
        end
    end

    mem_a_tile_buffer #(
        .LINE_W (LINE_W),
        .DEPTH  (ARRAY_HEIGHT),
        .IDX_W  (IDX_W)
    ) u_tile_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (start_i),
        .wr_en     (wr_en_s),
        .wr_idx    (line_cnt_r[IDX_W-1:0]),
        .wr_data   (mem_rdata),
        .tile_data (tile_data)
    );

    assign a_fifo_pop = pop_s;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign tile_valid = tile_valid_r;
    assign tile_count = tile_count_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_mem_a_data_reader.sv
// Directed + randomized bench for mem_a_data_reader with a FIFO/memory model
// and an address-order tile scoreboard.
module tb_mem_a_data_reader;

    localparam int LW = 256;
    localparam int H  = 4;
    localparam int TW = H * LW;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start_i = 1'b0;
    logic [15:0]     a_fifo_addr = 16'h0000;
    logic            a_fifo_empty = 1'b1;
    logic            a_fifo_pop;
    logic            mem_req;
    logic [15:0]     mem_addr;
    logic            mem_gnt = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [LW-1:0]   mem_rdata = '0;
    logic [TW-1:0]   tile_data;
    logic            tile_valid;
    logic            tile_ready = 1'b0;
    logic [15:0]     tile_count;
    logic            err_o;

    mem_a_data_reader #(
        .BUS_WIDTH_BYTES (32),
        .DATA_WIDTH_BYTES(1),
        .ARRAY_HEIGHT    (H)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .a_fifo_addr  (a_fifo_addr),
        .a_fifo_empty (a_fifo_empty),
        .a_fifo_pop   (a_fifo_pop),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .tile_data    (tile_data),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .tile_count   (tile_count),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          pop_cnt = 0;
    int          acc_cnt = 0;
    int          tiles_got = 0;
    bit          hide_mode = 1'b0;
    bit          gnt_rand = 1'b0;
    bit          ready_rand = 1'b0;
    logic        ready_lvl = 1'b0;
    int          resp_lat = 0;
    bit          resp_pend = 1'b0;
    int          resp_cnt = 0;
    logic [15:0] resp_addr = 16'h0000;
    int          gnt_wait = 0;
    logic        s_pop = 1'b0;
    logic        s_req = 1'b0;
    logic        s_tv = 1'b0;
    logic        s_err = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    function automatic logic [LW-1:0] pattern(input logic [15:0] a);
        return {8{a, ~a}};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        a_fifo_empty = (fifo_q.size() == 0) || (hide_mode && ($urandom_range(0, 2) == 0));
        a_fifo_addr  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic push(input logic [15:0] a);
        fifo_q.push_back(a);
        exp_q.push_back(a);
        drive_fifo();
    endtask

    // One clock: sample and score at negedge, then advance the FIFO/memory model
    task automatic cycle();
        logic        do_pop;
        logic        do_acc;
        logic [15:0] acc_a;
        @(negedge clk);
        s_pop = a_fifo_pop;
        s_req = mem_req;
        s_tv  = tile_valid;
        s_err = err_o;
        if (a_fifo_pop) chk("pop_on_empty", a_fifo_empty, 1'b0);
        if (prev_stall && mem_req) chk("addr_stable", mem_addr, prev_addr);
        prev_stall = mem_req && !mem_gnt;
        prev_addr  = mem_addr;
        do_pop = a_fifo_pop;
        do_acc = mem_req && mem_gnt;
        acc_a  = mem_addr;
        if (tile_valid && tile_ready) begin
            tiles_got++;
            chk("tile_expected", exp_q.size() >= H, 1'b1);
            if (exp_q.size() >= H) begin
                for (int k = 0; k < H; k++) begin
                    chk($sformatf("tile%0d_line%0d", tiles_got, k),
                        tile_data[k*LW +: LW], pattern(exp_q.pop_front()));
                end
            end
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        if (do_pop && (fifo_q.size() > 0)) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        mem_rvalid = 1'b0;
        if (do_acc) begin
            acc_cnt++;
            resp_pend = 1'b1;
            resp_cnt  = resp_lat;
            resp_addr = acc_a;
            gnt_wait  = gnt_rand ? int'($urandom_range(0, 5)) : 0;
        end
        if (resp_pend) begin
            if (resp_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pattern(resp_addr);
                resp_pend  = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
        mem_gnt = !resp_pend && (gnt_wait == 0);
        if (mem_req && (gnt_wait > 0)) gnt_wait--;
        drive_fifo();
        tile_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_lvl;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_tv && (n < budget));
        chk("tile_valid_wait", s_tv, 1'b1);
    endtask

    task automatic wait_tiles(input int target, input int budget);
        int n = 0;
        while ((tiles_got < target) && (n < budget)) begin
            cycle();
            n++;
        end
        chk("tiles_delivered", tiles_got, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pop"}, a_fifo_pop, 1'b0);
        chk({tag, "_req"}, mem_req, 1'b0);
        chk({tag, "_valid"}, tile_valid, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_addr"}, mem_addr, 16'h0000);
        chk({tag, "_count"}, tile_count, 16'h0000);
        for (int k = 0; k < H; k++) begin
            chk($sformatf("%s_line%0d", tag, k), tile_data[k*LW +: LW], '0);
        end
    endtask

    initial begin
        logic [TW-1:0] held;
        int            pc;
        int            tg;
        int            base;
        int            n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        cycle();
        cycle();

        // Spurious response while idle
        mem_rvalid = 1'b1;
        mem_rdata  = pattern(16'hBEEF);
        cycle();
        cycle();
        chk("err_spurious", s_err, 1'b1);
        for (int k = 0; k < H; k++) begin
            chk($sformatf("spurious_line%0d", k), tile_data[k*LW +: LW], '0);
        end

        // Preloaded FIFO, start, latency, first tile held under backpressure
        for (int i = 0; i < 8; i++) push(16'(16'h0010 * i));
        start_i = 1'b1;
        cycle();
        chk("start_no_pop", s_pop, 1'b0);
        cycle();
        chk("lat_pop_c0", s_pop, 1'b1);
        chk("lat_req_c0", s_req, 1'b0);
        chk("err_cleared", s_err, 1'b0);
        cycle();
        chk("lat_req_c1", s_req, 1'b1);
        chk("lat_pop_c1", s_pop, 1'b0);
        wait_valid(100);
        for (int k = 0; k < H; k++) begin
            chk($sformatf("tile1_line%0d_direct", k), tile_data[k*LW +: LW],
                pattern(16'(16'h0010 * k)));
        end
        held = tile_data;
        pc   = pop_cnt;
        repeat (20) begin
            cycle();
            chk("stall_data", tile_data === held, 1'b1);
            chk("stall_req", s_req, 1'b0);
            chk("stall_pop", s_pop, 1'b0);
            chk("stall_valid", s_tv, 1'b1);
        end
        chk("stall_pop_cnt", pop_cnt, pc);
        ready_lvl  = 1'b1;
        tile_ready = 1'b1;
        tg = tiles_got;
        cycle();
        cycle();
        chk("one_accept", tiles_got - tg, 1);
        chk("valid_dropped", s_tv, 1'b0);
        chk("tile_count_1", tile_count, 16'd1);

        // Random empty gaps, grant delays and backpressure
        hide_mode  = 1'b1;
        gnt_rand   = 1'b1;
        ready_rand = 1'b1;
        for (int i = 0; i < 12; i++) push({12'($urandom_range(0, 4095)), 4'h0});
        wait_tiles(5, 3000);
        chk("tile_count_5", tile_count, 16'd5);

        // Restart while a response is in flight
        hide_mode  = 1'b0;
        gnt_rand   = 1'b0;
        ready_rand = 1'b0;
        ready_lvl  = 1'b1;
        gnt_wait   = 0;
        repeat (5) cycle();
        resp_lat = 4;
        base = acc_cnt;
        for (int i = 0; i < 8; i++) push(16'(16'h0100 + 16'h0010 * i));
        n = 0;
        while ((acc_cnt < base + 2) && (n < 200)) begin
            cycle();
            n++;
        end
        chk("restart_reach_wait", acc_cnt, base + 2);
        start_i = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        tg = tiles_got;
        wait_tiles(tg + 1, 500);
        chk("restart_err", err_o, 1'b0);
        chk("restart_count", tile_count, 16'd1);
        resp_lat = 0;

        // Asynchronous reset while a tile is presented
        ready_lvl  = 1'b0;
        tile_ready = 1'b0;
        push(16'h0200);
        push(16'h0210);
        wait_valid(300);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        fifo_q.delete();
        exp_q.delete();
        resp_pend  = 1'b0;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        drive_fifo();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cycle();
        chk("post_reset_valid", s_tv, 1'b0);
        chk("post_reset_req", s_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
